phv_snap_resp: RTL and testbench

- CKV-domain responder for the AFC frequency-measurement handshake.
- Runs a free-running CKVD-edge counter (phv). On each toggle request from the REF-domain requester, it captures a snapshot and the difference from the previous snapshot.
- It then returns a toggle acknowledge, so the requester can read a stable count without metastability.
- It is the CKV-side counterpart of the REF-side sampling/window logic and replaces per-window sample-pulse capture.

---
 rtl/afc_pkg.sv | 6 +
 rtl/phv_snap_resp_toggle_sync.sv | 23 ++
 rtl/phv_snap_resp.sv | 84 ++++++++
 tb/tb_phv_snap_resp.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/afc_pkg.sv
// afc_pkg: shared types and sizing for the AFC frequency-measurement handshake.
package afc_pkg;
   localparam int WI        = 9;
   localparam int CNT_W_DEF = WI + 9;
   typedef enum logic [1:0] {IDLE, CAPT, HOLD} state_t;
endpackage

// File: rtl/phv_snap_resp_toggle_sync.sv
// toggle_sync: multi-stage synchronizer plus edge flop turning each level change into a one-cycle pulse.
module toggle_sync #(
   parameter int STAGES = 2
) (
   input  logic CLKSMP,
   input  logic NARST,
   input  logic en_i,
   input  logic tgl_i,
   output logic evt_o
);
   logic [STAGES-1:0] sync_q;
   logic              edge_q;
   // Freezing with en_i keeps an unseen level change in the pipe instead of dropping it.
   always_ff @(posedge CLKSMP or negedge NARST)
      if (!NARST) begin
         sync_q <= '0;
         edge_q <= 1'b0;
      end else if (en_i) begin
         sync_q <= {sync_q[STAGES-2:0], tgl_i};
         edge_q <= sync_q[STAGES-1];
      end
   assign evt_o = sync_q[STAGES-1] ^ edge_q;
endmodule

// File: rtl/phv_snap_resp.sv
// phv_snap_resp: CKV-side responder; snapshots the free-running phv counter per toggle request
// and returns a toggle acknowledge once the snapshot has been stable for HOLD_CYC cycles.
module phv_snap_resp
   import afc_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_CYC    = 1
) (
   input  logic             CLKSMP,
   input  logic             NARST,
   input  logic             EN,
   input  logic             REQ_TGL,
   output logic             ACK_TGL,
   output logic [CNT_W-1:0] SNAP,
   output logic [CNT_W-1:0] DIFF,
   output logic             DVALID,
   output logic             BUSY,
   output logic             ERR
);
   localparam logic [3:0] HOLD_LD = 4'(HOLD_CYC - 1);
   state_t           state_q;
   logic [CNT_W-1:0] phv_q, snap_q, diff_q, snap_prev_q, diff_d;
   logic [3:0]       hold_q;
   logic             ack_q, dvalid_q, first_q, pend_q, err_q, req_evt;
   toggle_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .CLKSMP (CLKSMP),
      .NARST  (NARST),
      .en_i   (EN),
      .tgl_i  (REQ_TGL),
      .evt_o  (req_evt)
   );
   assign diff_d = phv_q - snap_prev_q;
   always_ff @(posedge CLKSMP or negedge NARST)
      if (!NARST) begin
         state_q     <= IDLE;
         phv_q       <= '0;
         snap_q      <= '0;
         diff_q      <= '0;
         snap_prev_q <= '0;
         hold_q      <= '0;
         ack_q       <= 1'b0;
         dvalid_q    <= 1'b0;
         first_q     <= 1'b0;
         pend_q      <= 1'b0;
         err_q       <= 1'b0;
      end else if (EN) begin
         phv_q <= phv_q + 1'b1;
         case (state_q)
            IDLE:
               if (req_evt || pend_q) begin
                  state_q     <= CAPT;
                  // A fresh event arriving while a pending one is served stays queued.
                  pend_q      <= req_evt & pend_q;
                  snap_q      <= phv_q;
                  diff_q      <= diff_d;
                  snap_prev_q <= phv_q;
                  dvalid_q    <= dvalid_q | first_q;
                  first_q     <= 1'b1;
               end
            CAPT: begin
               state_q <= HOLD;
               hold_q  <= HOLD_LD;
            end
            HOLD:
               if (hold_q == 4'd0) begin
                  ack_q   <= ~ack_q;
                  state_q <= IDLE;
               end else
                  hold_q <= hold_q - 4'd1;
            default: state_q <= IDLE;
         endcase
         if (req_evt && state_q != IDLE) begin
            if (pend_q) err_q  <= 1'b1;
            else        pend_q <= 1'b1;
         end
      end
   assign ACK_TGL = ack_q;
   assign SNAP    = snap_q;
   assign DIFF    = diff_q;
   assign DVALID  = dvalid_q;
   assign BUSY    = (state_q != IDLE) | pend_q;
   assign ERR     = err_q;
endmodule

// File: tb/tb_phv_snap_resp.sv
// tb_phv_snap_resp: directed table-driven bench; an 18-bit and an 8-bit instance share stimulus.
module tb_phv_snap_resp;
   logic        CLKSMP = 1'b0, NARST = 1'b0, EN = 1'b0, REQ_TGL = 1'b0;
   logic        ack_a, ack_b, dv_a, dv_b, busy_a, busy_b, err_a, err_b;
   logic [17:0] snap_a, diff_a;
   logic [7:0]  snap_b, diff_b;
   int          m;
   int          checks = 0, errors = 0;
   logic        ack_exp = 1'b0;

   typedef struct {int at; int snap; int diff; logic dv;} vec_t;
   vec_t v[5];

   always #5 CLKSMP = ~CLKSMP;

   phv_snap_resp u_a (
      .CLKSMP (CLKSMP), .NARST (NARST), .EN (EN), .REQ_TGL (REQ_TGL),
      .ACK_TGL (ack_a), .SNAP (snap_a), .DIFF (diff_a), .DVALID (dv_a),
      .BUSY (busy_a), .ERR (err_a)
   );
   phv_snap_resp #(.CNT_W(8)) u_b (
      .CLKSMP (CLKSMP), .NARST (NARST), .EN (EN), .REQ_TGL (REQ_TGL),
      .ACK_TGL (ack_b), .SNAP (snap_b), .DIFF (diff_b), .DVALID (dv_b),
      .BUSY (busy_b), .ERR (err_b)
   );

   // Reference count of enabled edges: the phv value the DUT should hold.
   always @(posedge CLKSMP or negedge NARST)
      if (!NARST) m <= 0;
      else if (EN) m <= m + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_m(input int target);
      int n = 0;
      while (m != target && n < 5000) begin
         @(negedge CLKSMP);
         n++;
      end
      chk("reach_phv", m, target);
   endtask

   task automatic wait_ack(output int lat, output logic [4:0] bp);
      logic a0;
      a0  = ack_a;
      lat = 0;
      bp  = '0;
      for (int j = 0; j < 40; j++) begin
         @(negedge CLKSMP);
         if (j < 5) bp[j] = busy_a;
         if (ack_a !== a0) begin
            lat = j + 1;
            break;
         end
      end
   endtask

   task automatic serve_check(input string tag, input int snap_e, input int diff_e, input logic dv_e);
      int lat;
      logic [4:0] bp;
      wait_ack(lat, bp);
      ack_exp = ~ack_exp;
      chk({tag, "_lat"}, lat, 5);
      chk({tag, "_busy"}, 32'(bp), 32'(5'b01100));
      chk({tag, "_ack_a"}, 32'(ack_a), 32'(ack_exp));
      chk({tag, "_ack_b"}, 32'(ack_b), 32'(ack_exp));
      chk({tag, "_snap_a"}, 32'(snap_a), snap_e & 32'h3FFFF);
      chk({tag, "_diff_a"}, 32'(diff_a), diff_e & 32'h3FFFF);
      chk({tag, "_snap_b"}, 32'(snap_b), snap_e & 32'hFF);
      chk({tag, "_diff_b"}, 32'(diff_b), diff_e & 32'hFF);
      chk({tag, "_dv_a"}, 32'(dv_a), 32'(dv_e));
      chk({tag, "_dv_b"}, 32'(dv_b), 32'(dv_e));
   endtask

   initial begin
      int t0, mf, nack;
      logic a_prev;
      v[0] = '{8, 10, 10, 1'b0};
      v[1] = '{508, 510, 500, 1'b1};
      v[2] = '{545, 547, 37, 1'b1};
      v[3] = '{760, 762, 215, 1'b1};
      v[4] = '{780, 782, 20, 1'b1};
      repeat (3) @(negedge CLKSMP);
      chk("rst_ack", 32'(ack_a), 0);
      chk("rst_snap", 32'(snap_a), 0);
      chk("rst_busy_err", 32'({busy_a, err_a, dv_a}), 0);
      NARST = 1'b1;
      EN    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wait_m(v[i].at);
         REQ_TGL = ~REQ_TGL;
         serve_check($sformatf("vec%0d", i), v[i].snap, v[i].diff, v[i].dv);
         chk($sformatf("vec%0d_idle", i), 32'(busy_a), 0);
      end
      chk("no_err_yet", 32'({err_a, err_b}), 0);
      // Three back-to-back requests: second is queued, third collides with it.
      wait_m(800);
      t0 = m;
      REQ_TGL = ~REQ_TGL;
      @(negedge CLKSMP) REQ_TGL = ~REQ_TGL;
      @(negedge CLKSMP) REQ_TGL = ~REQ_TGL;
      nack   = 0;
      a_prev = ack_a;
      for (int j = 0; j < 30; j++) begin
         @(negedge CLKSMP);
         if (ack_a !== a_prev) nack++;
         a_prev = ack_a;
      end
      chk("ovl_acks", nack, 2);
      chk("ovl_err", 32'({err_a, err_b}), 32'(2'b11));
      chk("ovl_snap", 32'(snap_a), t0 + 5);
      chk("ovl_diff", 32'(diff_a), 3);
      chk("ovl_busy", 32'(busy_a), 0);
      // Freeze with a request arriving inside the frozen window.
      mf = m;
      EN = 1'b0;
      repeat (40) @(negedge CLKSMP);
      REQ_TGL = ~REQ_TGL;
      repeat (60) @(negedge CLKSMP);
      chk("frz_ack", 32'(ack_a), 32'(ack_exp));
      chk("frz_snap", 32'(snap_a), t0 + 5);
      chk("frz_busy", 32'(busy_a), 0);
      EN = 1'b1;
      serve_check("frz", mf + 2, mf + 2 - (t0 + 5), 1'b1);
      chk("frz_err_sticky", 32'(err_a), 1);
      // Reset asserted while the FSM sits in HOLD.
      wait_m(1000);
      REQ_TGL = ~REQ_TGL;
      repeat (4) @(negedge CLKSMP);
      chk("mid_busy", 32'(busy_a), 1);
      #1 NARST = 1'b0;
      #1;
      chk("mid_ack", 32'({ack_a, ack_b}), 0);
      chk("mid_snap", 32'(snap_a), 0);
      chk("mid_diff", 32'(diff_a), 0);
      chk("mid_flags", 32'({dv_a, busy_a, err_a, dv_b, busy_b, err_b}), 0);
      ack_exp = 1'b0;
      @(negedge CLKSMP) NARST = 1'b1;
      wait_m(5);
      REQ_TGL = ~REQ_TGL;
      serve_check("post_rst", 7, 7, 1'b0);
      chk("post_rst_err", 32'(err_a), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
